fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single push port of the synchronous FIFO among N independent producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and forwards its data to the FIFO push interface. It honours FIFO full backpressure and never pushes while full. The block sits directly in front of the FIFO write port; the FIFO read side is untouched.

## Interface
- N, 4, number of requesters (≥2)
- WIDTH, 8, data width; equals the FIFO WIDTH
- MAX_BURST, 4, maximum beats per grant (≥1)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  N  per-requester data valid
- req_data  input  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
- req_ready  output  N  per-requester accept; beat transfers when valid & ready
- grant  output  N  one-hot current owner; all zero when idle
- fifo_push  output  1  to FIFO push
- fifo_data  output  WIDTH  to FIFO data_i
- fifo_full  input  1  from FIFO full

## Operation

State registers:
- state: IDLE or BURST
- owner: index of the current owner
- last: index of the previous owner
- beats: beat counter, $clog2(MAX_BURST)+1 bits

Reset values: state=IDLE, last=N-1 (so requester 0 has first priority), owner=0, beats=0.

While rst=1, all outputs are forced to 0 combinationally: req_ready, grant, fifo_push and fifo_data.

IDLE:
- grant=0, req_ready=0, fifo_push=0, fifo_data=0.
- If any req_valid bit is set, choose the first set bit searching (last+1) mod N upward with wrap-around.
- Then owner<=that index, beats<=0, state<=BURST.
- If no req_valid bit is set, stay in IDLE.

BURST:
- grant=onehot(owner).
- req_ready[owner]=~fifo_full; every other req_ready bit is 0.
- fifo_push=req_valid[owner] & ~fifo_full.
- fifo_data=req_data[owner] (driven regardless of push).
- A transfer is fifo_push=1. On a transfer, beats<=beats+1.
- Release when either:
  - a transfer occurs with beats==MAX_BURST-1, or
  - req_valid[owner]==0 in the current cycle (no transfer that cycle).
- On release: last<=owner, state<=IDLE.
- fifo_full=1 with valid high is a stall: no transfer, no release, beats held. There is no stall timeout.

Boundary conditions:
- Requesters must keep valid and data stable until ready; the arbiter does not check this.
- A requester that is the only one valid is re-granted after the idle cycle.
- Non-owner valid bits never affect outputs during BURST.
- MAX_BURST=1: every transfer releases.
- N not a power of two: the wrap-around index stays in 0..N-1.

## Timing
- Grant latency: req_valid high in IDLE at cycle t gives grant at t+1. The first push is at t+1 if not full.
- The arbiter has no pipeline. fifo_push, fifo_data and req_ready are combinational from registered state, the owner's valid and data, and fifo_full. The FIFO samples push at the same edge as the handshake.
- One mandatory IDLE cycle follows every release.
- Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Reset mid-burst: outputs are 0 during the rst cycle and no beat is transferred. The block is in IDLE the cycle after rst deasserts, with last=N-1.

## Test plan
- Reset, then requester 0 valid with data 0x11..0x16 (6 beats), MAX_BURST=4, fifo never full:
  - pushes 0x11–0x14 on cycles 1–4
  - grant=0 on cycle 5
  - regrant on cycle 6, pushes 0x15–0x16 on cycles 6–7
  - release on cycle 8 (valid low)
- All 4 requesters continuously valid:
  - grant sequence 0001, 0010, 0100, 1000, 0001
  - exactly 4 pushes per grant, one idle cycle between grants
  - data order matches owner
- fifo_full high for 3 cycles after the owner's 2nd beat:
  - fifo_push=0 and req_ready=0 for those 3 cycles
  - grant unchanged
  - beats 3–4 push afterwards, then release
- Requester 1 owner drops valid after 2 beats while requesters 0 and 3 are valid:
  - release
  - idle cycle
  - grant goes to 3, then 0
- rst asserted during requester 2's 2nd beat:
  - all outputs 0 in the rst cycle, no push
  - after rst deasserts, with requesters 0 and 2 valid, grant goes to 0 first
- N=3 with last=2 and requesters 0 and 2 valid: grant wraps to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among N valid/ready producers.
// A grant lasts up to MAX_BURST beats and is always followed by one idle cycle.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         grant,
    output logic                 fifo_push,
    output logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_full
);

    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST) + 1;
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    owner_q;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    owner_d;
    logic [BEAT_W-1:0]   beats_q;
    logic [BEAT_W-1:0]   beats_d;
    logic [WIDTH-1:0]    data_arr [N];
    logic                own_valid;
    logic                xfer;
    logic                last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Search starts just after the previous owner; the modulo keeps non-power-of-two N in range.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] v,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && v[idx[IDX_W-1:0]]) begin
                sel   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign owner_d   = rr_pick(req_valid, last_q);
    assign own_valid = req_valid[owner_q];
    assign xfer      = !rst && (state_q == BURST) && own_valid && !fifo_full;
    assign last_beat = (beats_q == BEAT_LAST);
    assign beats_d   = beats_q + BEAT_W'(1);

    always_comb begin
        req_ready = '0;
        grant     = '0;
        fifo_push = 1'b0;
        fifo_data = '0;
        if (!rst && state_q == BURST) begin
            grant[owner_q]     = 1'b1;
            req_ready[owner_q] = !fifo_full;
            fifo_push          = xfer;
            fifo_data          = data_arr[owner_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            beats_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        owner_q <= owner_d;
                        beats_q <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    // A full FIFO with valid high is a stall: nothing moves.
                    if (xfer) begin
                        beats_q <= beats_d;
                        if (last_beat) begin
                            last_q  <= owner_q;
                            state_q <= IDLE;
                        end
                    end else if (!own_valid) begin
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a round-robin reference model
// compared every cycle, and directed cycle-by-cycle literal expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_data = '0;
    logic             fifo_full = 1'b0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     grant;
    logic             fifo_push;
    logic [W-1:0]     fifo_data;

    logic [2:0]       b_valid = '0;
    logic [23:0]      b_data = '0;
    logic             b_full = 1'b0;
    logic [2:0]       b_ready;
    logic [2:0]       b_grant;
    logic             b_push;
    logic [7:0]       b_fdata;

    fifo_wr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .grant(grant), .fifo_push(fifo_push),
        .fifo_data(fifo_data), .fifo_full(fifo_full)
    );

    fifo_wr_arbiter #(.N(3), .WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .grant(b_grant), .fifo_push(b_push),
        .fifo_data(b_fdata), .fifo_full(b_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer queues: valid whenever a queue holds data, pop on an observed handshake.
    logic [7:0]   mem [N][16];
    int           head [N];
    int           tail [N];
    logic [N-1:0] acc_n = '0;

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic put(input int i, input logic [7:0] d);
        mem[i][tail[i]] = d;
        tail[i]++;
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = mem[i][head[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc_n[i]) head[i]++;
    endtask

    task automatic cyc();
        step();
        refresh();
    endtask

    task automatic lit(input string name, input logic [3:0] g, input logic p,
                       input logic [3:0] r, input logic [7:0] d);
        @(negedge clk);
        chk({name, " grant"}, 32'(grant), 32'(g));
        chk({name, " push"}, 32'(fifo_push), 32'(p));
        chk({name, " ready"}, 32'(req_ready), 32'(r));
        chk({name, " data"}, 32'(fifo_data), 32'(d));
    endtask

    task automatic litb(input string name, input logic [2:0] g, input logic p,
                        input logic [7:0] d);
        @(negedge clk);
        chk({name, " grant"}, 32'(b_grant), 32'(g));
        chk({name, " push"}, 32'(b_push), 32'(p));
        chk({name, " data"}, 32'(b_fdata), 32'(d));
    endtask

    task automatic reset_dut();
        step();
        rst       = 1'b1;
        fifo_full = 1'b0;
        b_valid   = '0;
        clear_q();
        refresh();
        lit("in reset", 4'b0, 1'b0, 4'b0, 8'h00);
        step();
        rst = 1'b0;
    endtask

    // Reference model: who holds the port (-1 = nobody), who held it last, beats granted.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_beats = 0;

    function automatic int rr_first(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= -1;
            m_last  <= N - 1;
            m_beats <= 0;
        end else if (m_owner < 0) begin
            if (req_valid != '0) begin
                m_owner <= rr_first(req_valid, m_last);
                m_beats <= 0;
            end
        end else if (req_valid[m_owner] && !fifo_full) begin
            m_beats <= m_beats + 1;
            if (m_beats + 1 == MB) begin
                m_owner <= -1;
                m_last  <= m_owner;
            end
        end else if (!req_valid[m_owner]) begin
            m_owner <= -1;
            m_last  <= m_owner;
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        logic [3:0] er;
        logic       ep;
        logic [7:0] ed;
        eg = '0;
        er = '0;
        ep = 1'b0;
        ed = '0;
        if (!rst && m_owner >= 0) begin
            eg = 4'(1 << m_owner);
            er = fifo_full ? 4'b0 : eg;
            ep = req_valid[m_owner] && !fifo_full;
            ed = req_data[m_owner*W +: W];
        end
        chk("model grant", 32'(grant), 32'(eg));
        chk("model ready", 32'(req_ready), 32'(er));
        chk("model push", 32'(fifo_push), 32'(ep));
        chk("model data", 32'(fifo_data), 32'(ed));
        acc_n <= req_valid & req_ready;
    end

    int cnt [N];

    initial begin
        clear_q();
        refresh();
        lit("power-on reset", 4'b0, 1'b0, 4'b0, 8'h00);

        // Single requester, 6 beats: burst of 4, idle, burst of 2, release on valid low.
        reset_dut();
        for (int k = 0; k < 6; k++) put(0, 8'(8'h11 + k));
        refresh();
        lit("t1 c0", 4'b0, 1'b0, 4'b0, 8'h00);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            lit($sformatf("t1 c%0d", c), 4'b0001, 1'b1, 4'b0001, 8'(8'h10 + c));
        end
        cyc(); lit("t1 c5", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t1 c6", 4'b0001, 1'b1, 4'b0001, 8'h15);
        cyc(); lit("t1 c7", 4'b0001, 1'b1, 4'b0001, 8'h16);
        cyc(); lit("t1 c8", 4'b0001, 1'b0, 4'b0001, 8'h00);
        cyc(); lit("t1 c9", 4'b0000, 1'b0, 4'b0000, 8'h00);

        // All requesters valid: 0,1,2,3,0 with four beats each and an idle between.
        reset_dut();
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < 8; k++) put(i, 8'(64 + 16*i + k));
        end
        refresh();
        for (int g = 0; g < 5; g++) begin
            lit($sformatf("t2 idle%0d", g), 4'b0, 1'b0, 4'b0, 8'h00);
            for (int b = 0; b < 4; b++) begin
                cyc();
                lit($sformatf("t2 g%0d b%0d", g, b), 4'(1 << (g % 4)), 1'b1,
                    4'(1 << (g % 4)), 8'(64 + 16*(g % 4) + cnt[g % 4]));
                cnt[g % 4]++;
            end
            cyc();
        end

        // FIFO full for three cycles after the owner's second beat.
        reset_dut();
        put(0, 8'hA1); put(0, 8'hA2); put(0, 8'hA3); put(0, 8'hA4);
        put(1, 8'hB9);
        refresh();
        lit("t3 c0", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t3 c1", 4'b0001, 1'b1, 4'b0001, 8'hA1);
        cyc(); lit("t3 c2", 4'b0001, 1'b1, 4'b0001, 8'hA2);
        step(); fifo_full = 1'b1; refresh();
        lit("t3 stall1", 4'b0001, 1'b0, 4'b0000, 8'hA3);
        cyc(); lit("t3 stall2", 4'b0001, 1'b0, 4'b0000, 8'hA3);
        cyc(); lit("t3 stall3", 4'b0001, 1'b0, 4'b0000, 8'hA3);
        step(); fifo_full = 1'b0; refresh();
        lit("t3 c6", 4'b0001, 1'b1, 4'b0001, 8'hA3);
        cyc(); lit("t3 c7", 4'b0001, 1'b1, 4'b0001, 8'hA4);
        cyc(); lit("t3 c8", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t3 c9", 4'b0010, 1'b1, 4'b0010, 8'hB9);
        cyc(); lit("t3 c10", 4'b0010, 1'b0, 4'b0010, 8'h00);

        // Owner 1 drops valid after two beats while 0 and 3 wait: next is 3, then 0.
        reset_dut();
        put(1, 8'hB1); put(1, 8'hB2);
        refresh();
        lit("t4 c0", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t4 c1", 4'b0010, 1'b1, 4'b0010, 8'hB1);
        step(); put(0, 8'hC1); put(3, 8'hD1); put(3, 8'hD2); refresh();
        lit("t4 c2", 4'b0010, 1'b1, 4'b0010, 8'hB2);
        cyc(); lit("t4 c3", 4'b0010, 1'b0, 4'b0010, 8'h00);
        cyc(); lit("t4 c4", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t4 c5", 4'b1000, 1'b1, 4'b1000, 8'hD1);
        cyc(); lit("t4 c6", 4'b1000, 1'b1, 4'b1000, 8'hD2);
        cyc(); lit("t4 c7", 4'b1000, 1'b0, 4'b1000, 8'h00);
        cyc(); lit("t4 c8", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t4 c9", 4'b0001, 1'b1, 4'b0001, 8'hC1);
        cyc(); lit("t4 c10", 4'b0001, 1'b0, 4'b0001, 8'h00);

        // Reset during requester 2's second beat; afterwards requester 0 wins first.
        reset_dut();
        put(2, 8'hE1); put(2, 8'hE2); put(2, 8'hE3);
        refresh();
        lit("t5 c0", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t5 c1", 4'b0100, 1'b1, 4'b0100, 8'hE1);
        step(); rst = 1'b1; refresh();
        lit("t5 rst", 4'b0000, 1'b0, 4'b0000, 8'h00);
        step(); rst = 1'b0; put(0, 8'hF1); refresh();
        lit("t5 c3", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t5 c4", 4'b0001, 1'b1, 4'b0001, 8'hF1);
        cyc(); lit("t5 c5", 4'b0001, 1'b0, 4'b0001, 8'h00);
        cyc(); lit("t5 c6", 4'b0000, 1'b0, 4'b0000, 8'h00);
        cyc(); lit("t5 c7", 4'b0100, 1'b1, 4'b0100, 8'hE2);

        // N=3, MAX_BURST=1: one beat per grant, wrap from 2 back to 0.
        reset_dut();
        b_valid = 3'b100;
        b_data  = 24'hC2C1C0;
        litb("t6 c0", 3'b000, 1'b0, 8'h00);
        step(); litb("t6 c1", 3'b100, 1'b1, 8'hC2);
        step(); b_valid = 3'b101;
        litb("t6 c2", 3'b000, 1'b0, 8'h00);
        step(); litb("t6 c3", 3'b001, 1'b1, 8'hC0);
        step(); litb("t6 c4", 3'b000, 1'b0, 8'h00);
        step(); litb("t6 c5", 3'b100, 1'b1, 8'hC2);
        step(); b_valid = 3'b000;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
